// File: rtl/motor_ramp_pwm_driver.sv
// motor_ramp_pwm_driver
// Slew-rate limits an 8-bit speed command into a ramped duty value.
// It drives complementary high/low gate signals from that duty with a
// programmable dead-time. Fault ramps the duty down to zero. Dropping
// enable forces both gates off on the next edge.
//
// Handshake: target_speed is qualified by target_valid, a single-cycle
// strobe. There is no back-pressure. The value is latched on any clock
// edge where ena=1 and target_valid=1, and target_valid is ignored while
// ena=0.
//
// dbg_state exposes the gate FSM state for checkers:
// 0=OFF, 1=DEAD, 2=HI, 3=LO.
module motor_ramp_pwm_driver #(
  parameter int RAMP_DIV = 256,
  parameter int DEADTIME = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] target_speed,
  input  logic       target_valid,
  input  logic       enable,
  input  logic       fault,
  output logic       pwm_hi,
  output logic       pwm_lo,
  output logic [7:0] speed_now,
  output logic       at_target,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } gate_state_e;

  localparam logic [15:0] PRESC_LAST = 16'(RAMP_DIV - 1);
  localparam logic [3:0]  DEAD_LOAD  = 4'(DEADTIME - 1);
  localparam logic [7:0]  PWM_LAST   = 8'd254;

  logic [7:0]  target_reg;
  logic [7:0]  eff_target;
  logic [15:0] presc;
  logic        ramp_tick;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_lat;
  logic        demand;
  logic [3:0]  dead_cnt;
  logic [3:0]  dead_cnt_nxt;
  gate_state_e state;
  gate_state_e state_nxt;

  // Latch the commanded speed. It is kept through fault and enable=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_reg <= 8'd0;
    end else if (ena && target_valid) begin
      target_reg <= target_speed;
    end
  end

  // Fault or loss of enable steers the ramp toward zero.
  assign eff_target = (fault || !enable) ? 8'd0 : target_reg;
  assign ramp_tick  = (presc == PRESC_LAST);
  assign at_target  = (speed_now == eff_target);
  assign busy       = !at_target;

  // The prescaler issues a tick on its wrap.
  // Each tick moves speed_now one step toward the effective target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= 16'd0;
      speed_now <= 8'd0;
    end else if (ena) begin
      if (!enable) begin
        presc     <= 16'd0;
        speed_now <= 8'd0;
      end else begin
        presc <= ramp_tick ? 16'd0 : presc + 16'd1;
        if (ramp_tick) begin
          if (speed_now < eff_target) begin
            speed_now <= speed_now + 8'd1;
          end else if (speed_now > eff_target) begin
            speed_now <= speed_now - 8'd1;
          end
        end
      end
    end
  end

  // PWM period counter, 0..254.
  // The duty is latched only at the wrap, so a period is never cut mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= 8'd0;
      duty_lat <= 8'd0;
    end else if (ena) begin
      if (!enable) begin
        pwm_cnt  <= 8'd0;
        duty_lat <= 8'd0;
      end else if (pwm_cnt == PWM_LAST) begin
        pwm_cnt  <= 8'd0;
        duty_lat <= speed_now;
      end else begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

  // The counter tops out at 254, so a duty of 255 keeps demand high
  // for the whole period.
  assign demand = (pwm_cnt < duty_lat);

  // Gate FSM next-state logic.
  // Loss of enable overrides everything, even while ena=0.
  always_comb begin
    state_nxt    = state;
    dead_cnt_nxt = dead_cnt;
    if (!enable) begin
      state_nxt = ST_OFF;
    end else if (ena) begin
      case (state)
        ST_OFF: begin
          state_nxt    = ST_DEAD;
          dead_cnt_nxt = DEAD_LOAD;
        end
        ST_DEAD: begin
          if (dead_cnt == 4'd0) begin
            state_nxt = demand ? ST_HI : ST_LO;
          end else begin
            dead_cnt_nxt = dead_cnt - 4'd1;
          end
        end
        ST_HI: begin
          if (!demand) begin
            state_nxt    = ST_DEAD;
            dead_cnt_nxt = DEAD_LOAD;
          end
        end
        ST_LO: begin
          if (demand) begin
            state_nxt    = ST_DEAD;
            dead_cnt_nxt = DEAD_LOAD;
          end
        end
        default: begin
          state_nxt = ST_OFF;
        end
      endcase
    end
  end

  // State register and registered gate decode.
  // The gates are decoded from state_nxt, so they line up with the state
  // and can never be high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      dead_cnt <= 4'd0;
      pwm_hi   <= 1'b0;
      pwm_lo   <= 1'b0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_cnt_nxt;
      pwm_hi   <= (state_nxt == ST_HI);
      pwm_lo   <= (state_nxt == ST_LO);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_motor_ramp_pwm_driver.sv
// Bench for motor_ramp_pwm_driver with RAMP_DIV=4 and DEADTIME=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_motor_ramp_pwm_driver;

  localparam int RAMP_DIV = 4;
  localparam int DEADTIME = 4;
  localparam int W        = 16;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] target_speed;
  logic       target_valid;
  logic       enable;
  logic       fault;
  logic       pwm_hi;
  logic       pwm_lo;
  logic [7:0] speed_now;
  logic       at_target;
  logic       busy;
  logic [1:0] dbg_state;

  int checks      = 0;
  int failures    = 0;
  int overlap_cnt = 0;
  logic [W-1:0] exp_q[$];

  motor_ramp_pwm_driver #(.RAMP_DIV(RAMP_DIV), .DEADTIME(DEADTIME)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .target_speed(target_speed),
    .target_valid(target_valid), .enable(enable), .fault(fault),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .speed_now(speed_now),
    .at_target(at_target), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // The two gates must never be high together.
  always @(negedge clk) begin
    if (rst_n && pwm_hi && pwm_lo) overlap_cnt++;
  end

  // ---------------- driver / wait tasks (no comparisons) ----------------
  // Called at a falling edge; target_speed is latched on the next rising edge.
  task automatic drive_target(input logic [7:0] t);
    target_speed = t;
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic wait_speed_change(input int limit, output logic [7:0] val,
                                   output int gap, output bit timed_out);
    logic [7:0] start;
    start     = speed_now;
    val       = speed_now;
    gap       = 0;
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      gap++;
      if (speed_now !== start) begin
        val       = speed_now;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_speed(input logic [7:0] v, input int limit, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (speed_now === v) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Returns how many cycles the current {pwm_hi,pwm_lo} pattern lasts.
  // It returns at the first cycle of the next pattern.
  task automatic wait_gate(input int limit, output int len, output bit timed_out);
    logic [1:0] pat;
    pat       = {pwm_hi, pwm_lo};
    len       = 1;
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ({pwm_hi, pwm_lo} !== pat) begin
        timed_out = 1'b0;
        break;
      end
      len++;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; enable = 1'b0; fault = 1'b0;
    target_valid = 1'b0; target_speed = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_hi, pwm_lo} !== 2'b00) begin
      failures++; $display("FAIL reset_gates got=%b exp=00", {pwm_hi, pwm_lo});
    end
    checks++;
    if (speed_now !== 8'd0) begin
      failures++; $display("FAIL reset_speed got=%0d exp=0", speed_now);
    end
    checks++;
    if ({at_target, busy} !== 2'b10) begin
      failures++; $display("FAIL reset_flags got=%b exp=10", {at_target, busy});
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_hi, pwm_lo, dbg_state} !== 4'b0000) begin
      failures++; $display("FAIL off_hold got=%b exp=0000", {pwm_hi, pwm_lo, dbg_state});
    end
  endtask

  task automatic test_enable_start();
    int  lat;
    bit  hi_seen;
    logic [1:0] st1;
    logic [W-1:0] e;
    lat = -1; hi_seen = 1'b0; st1 = 2'd0;
    exp_q.push_back(W'(DEADTIME + 1));
    enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) st1 = dbg_state;
      if (pwm_hi) hi_seen = 1'b1;
      if (pwm_lo) begin lat = n; break; end
    end
    e = exp_q.pop_front();
    checks++;
    if (lat !== int'(e)) begin
      failures++; $display("FAIL start_lo_latency got=%0d exp=%0d", lat, e);
    end
    checks++;
    if (st1 !== 2'd1) begin
      failures++; $display("FAIL start_dead_state got=%0d exp=1", st1);
    end
    checks++;
    if (hi_seen || !at_target) begin
      failures++; $display("FAIL start_hi_quiet got=hi%0d/at%0d exp=hi0/at1", hi_seen, at_target);
    end
  endtask

  task automatic test_ramp();
    logic [7:0] v; int g; bit to; bit first; int total;
    logic [W-1:0] e;
    drive_target(8'd10);
    checks++;
    if ({busy, speed_now} !== {1'b1, 8'd0}) begin
      failures++; $display("FAIL ramp_busy_start got=busy%0d/spd%0d exp=busy1/spd0", busy, speed_now);
    end
    for (int s = 1; s <= 10; s++) exp_q.push_back(W'(s));
    first = 1'b1; total = 0;
    while (exp_q.size() != 0) begin
      wait_speed_change(RAMP_DIV + 2, v, g, to);
      e = exp_q.pop_front();
      total += g;
      checks++;
      if (to || v !== e[7:0] || g > RAMP_DIV || (!first && g != RAMP_DIV) ||
          busy !== (e[7:0] != 8'd10)) begin
        failures++;
        $display("FAIL ramp_step got=%0d gap=%0d busy=%0d exp=%0d gap=%0d", v, g, busy, e[7:0], RAMP_DIV);
        if (to) exp_q.delete();
      end
      first = 1'b0;
    end
    checks++;
    if (total > 10 * RAMP_DIV || total < 9 * RAMP_DIV + 1) begin
      failures++; $display("FAIL ramp_total got=%0d exp=%0d..%0d", total, 9 * RAMP_DIV + 1, 10 * RAMP_DIV);
    end
    repeat (3 * RAMP_DIV) @(negedge clk);
    checks++;
    if ({speed_now, at_target, busy} !== {8'd10, 1'b1, 1'b0}) begin
      failures++; $display("FAIL ramp_hold got=%0d/%0d/%0d exp=10/1/0", speed_now, at_target, busy);
    end
  endtask

  task automatic test_pwm_steady();
    bit to; int len; logic [1:0] pat;
    logic [W-1:0] e;
    drive_target(8'd128);
    wait_speed(8'd128, 130 * RAMP_DIV, to);
    checks++;
    if (to) begin failures++; $display("FAIL pwm_reach128 got=%0d exp=128", speed_now); end
    repeat (2 * 255) @(negedge clk);
    // The HI gate rises DEADTIME+1 cycles after demand rises.
    // It falls 1 cycle after demand falls. Demand is high for 128 of 255
    // cycles, so HI lasts 128-DEADTIME and LO lasts 255-128-DEADTIME.
    exp_q.push_back({6'd0, 2'b10, 8'(128 - DEADTIME)});
    exp_q.push_back({6'd0, 2'b00, 8'(DEADTIME)});
    exp_q.push_back({6'd0, 2'b01, 8'(255 - 128 - DEADTIME)});
    exp_q.push_back({6'd0, 2'b00, 8'(DEADTIME)});
    for (int i = 0; i < 8; i++) begin
      wait_gate(300, len, to);
      if (to || {pwm_hi, pwm_lo} == 2'b10) break;
    end
    while (exp_q.size() != 0) begin
      pat = {pwm_hi, pwm_lo};
      wait_gate(300, len, to);
      e = exp_q.pop_front();
      checks++;
      if (to || pat !== e[9:8] || len != int'(e[7:0])) begin
        failures++; $display("FAIL pwm_segment got=%b/%0d exp=%b/%0d", pat, len, e[9:8], e[7:0]);
      end
    end
  endtask

  task automatic test_fault();
    logic [7:0] v; int g; bit to; bit first;
    logic [W-1:0] e;
    drive_target(8'd20);
    wait_speed(8'd20, 120 * RAMP_DIV, to);
    checks++;
    if (to) begin failures++; $display("FAIL fault_reach20 got=%0d exp=20", speed_now); end
    repeat (5) @(negedge clk);
    fault = 1'b1;
    for (int s = 19; s >= 0; s--) exp_q.push_back(W'(s));
    first = 1'b1;
    while (exp_q.size() != 0) begin
      wait_speed_change(RAMP_DIV + 2, v, g, to);
      e = exp_q.pop_front();
      checks++;
      if (to || v !== e[7:0] || g > RAMP_DIV || (!first && g != RAMP_DIV)) begin
        failures++; $display("FAIL fault_down got=%0d gap=%0d exp=%0d gap=%0d", v, g, e[7:0], RAMP_DIV);
        if (to) exp_q.delete();
      end
      first = 1'b0;
    end
    repeat (3 * RAMP_DIV) @(negedge clk);
    checks++;
    if ({speed_now, at_target} !== {8'd0, 1'b1}) begin
      failures++; $display("FAIL fault_hold0 got=%0d/%0d exp=0/1", speed_now, at_target);
    end
    fault = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL fault_release_busy got=%0d exp=1", busy); end
    for (int s = 1; s <= 20; s++) exp_q.push_back(W'(s));
    first = 1'b1;
    while (exp_q.size() != 0) begin
      wait_speed_change(RAMP_DIV + 2, v, g, to);
      e = exp_q.pop_front();
      checks++;
      if (to || v !== e[7:0] || (!first && g != RAMP_DIV)) begin
        failures++; $display("FAIL fault_resume got=%0d gap=%0d exp=%0d", v, g, e[7:0]);
        if (to) exp_q.delete();
      end
      first = 1'b0;
    end
    checks++;
    if (at_target !== 1'b1) begin failures++; $display("FAIL fault_target_kept got=%0d exp=1", at_target); end
  endtask

  task automatic test_enable_drop();
    int lat; int bad; bit hi_seen;
    logic [W-1:0] e;
    repeat ($urandom_range(20, 200)) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({pwm_hi, pwm_lo, speed_now, at_target, dbg_state} !== {2'b00, 8'd0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL drop_off got=hi%0d lo%0d spd%0d at%0d st%0d exp=0 0 0 1 0", pwm_hi, pwm_lo, speed_now, at_target, dbg_state);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (pwm_hi || pwm_lo || speed_now != 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL drop_stay_off got=%0d exp=0", bad); end
    exp_q.push_back(W'(DEADTIME + 1));
    enable = 1'b1;
    lat = -1; hi_seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (pwm_hi) hi_seen = 1'b1;
      if (pwm_lo) begin lat = n; break; end
    end
    e = exp_q.pop_front();
    checks++;
    if (lat !== int'(e) || hi_seen) begin
      failures++; $display("FAIL reenable_lo got=%0d hi=%0d exp=%0d hi=0", lat, hi_seen, e);
    end
  endtask

  task automatic test_duty_extremes();
    bit to; int bad;
    drive_target(8'd255);
    wait_speed(8'd255, 260 * RAMP_DIV, to);
    checks++;
    if (to) begin failures++; $display("FAIL duty255_reach got=%0d exp=255", speed_now); end
    repeat (2 * 255 + 10) @(negedge clk);
    bad = 0;
    repeat (2 * 255) begin
      @(negedge clk);
      if (pwm_hi !== 1'b1 || pwm_lo !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL duty255_hi_const got=%0d exp=0", bad); end
    drive_target(8'd0);
    wait_speed(8'd0, 260 * RAMP_DIV, to);
    checks++;
    if (to) begin failures++; $display("FAIL duty0_reach got=%0d exp=0", speed_now); end
    repeat (2 * 255 + 10) @(negedge clk);
    bad = 0;
    repeat (2 * 255) begin
      @(negedge clk);
      if (pwm_lo !== 1'b1 || pwm_hi !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL duty0_lo_const got=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v; int g; bit to;
    logic [W-1:0] e;
    drive_target(8'd40);
    wait_speed(8'd10, 14 * RAMP_DIV, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_reach10 got=%0d exp=10", speed_now); end
    // Retarget mid-ramp; the ramp turns around from the current value.
    drive_target(8'd5);
    for (int s = 9; s >= 5; s--) exp_q.push_back(W'(s));
    while (exp_q.size() != 0) begin
      wait_speed_change(RAMP_DIV + 2, v, g, to);
      e = exp_q.pop_front();
      checks++;
      if (to || v !== e[7:0]) begin
        failures++; $display("FAIL retarget_step got=%0d exp=%0d", v, e[7:0]);
        if (to) exp_q.delete();
      end
    end
    // Two strobes on consecutive cycles; the later one wins.
    target_speed = 8'd50; target_valid = 1'b1;
    @(negedge clk);
    target_speed = 8'd30;
    @(negedge clk);
    target_valid = 1'b0;
    for (int s = 6; s <= 30; s++) exp_q.push_back(W'(s));
    while (exp_q.size() != 0) begin
      wait_speed_change(RAMP_DIV + 2, v, g, to);
      e = exp_q.pop_front();
      checks++;
      if (to || v !== e[7:0]) begin
        failures++; $display("FAIL b2b_step got=%0d exp=%0d", v, e[7:0]);
        if (to) exp_q.delete();
      end
    end
    repeat (4 * RAMP_DIV) @(negedge clk);
    checks++;
    if ({speed_now, at_target} !== {8'd30, 1'b1}) begin
      failures++; $display("FAIL b2b_final got=%0d/%0d exp=30/1", speed_now, at_target);
    end
  endtask

  task automatic test_ena_hold();
    int changes; logic [1:0] pat0; bit to;
    ena = 1'b0;
    @(negedge clk);
    pat0 = {pwm_hi, pwm_lo};
    drive_target(8'd100);
    changes = 0;
    repeat (20) begin
      @(negedge clk);
      if (speed_now !== 8'd30 || {pwm_hi, pwm_lo} !== pat0) changes++;
    end
    checks++;
    if (changes != 0) begin failures++; $display("FAIL ena_hold got=%0d exp=0", changes); end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({pwm_hi, pwm_lo, dbg_state, speed_now} !== {2'b00, 2'd0, 8'd30}) begin
      failures++; $display("FAIL ena0_drop got=%b st%0d spd%0d exp=00 st0 spd30", {pwm_hi, pwm_lo}, dbg_state, speed_now);
    end
    ena = 1'b1;
    @(negedge clk);
    checks++;
    if (speed_now !== 8'd0) begin failures++; $display("FAIL ena1_clear got=%0d exp=0", speed_now); end
    enable = 1'b1;
    wait_speed(8'd30, 34 * RAMP_DIV, to);
    repeat (4 * RAMP_DIV) @(negedge clk);
    checks++;
    if (to || speed_now !== 8'd30 || at_target !== 1'b1) begin
      failures++; $display("FAIL ena_ignored_strobe got=%0d exp=30", speed_now);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pwm_hi) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL areset_hi_seen got=0 exp=1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_hi, pwm_lo, speed_now} !== {2'b00, 8'd0}) begin
      failures++; $display("FAIL areset_immediate got=%b spd%0d exp=00 spd0", {pwm_hi, pwm_lo}, speed_now);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_invariant();
    checks++;
    if (overlap_cnt != 0) begin
      failures++; $display("FAIL gate_overlap got=%0d exp=0", overlap_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; ena = 1'b1; enable = 1'b0; fault = 1'b0;
    target_valid = 1'b0; target_speed = 8'd0;
    @(negedge clk);
    test_reset();
    test_enable_start();
    test_ramp();
    test_pwm_steady();
    test_fault();
    test_enable_drop();
    test_duty_extremes();
    test_back_to_back();
    test_ena_hold();
    test_async_reset();
    test_invariant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
